modbus_tx_frame_seq: RTL and testbench

//  Sequences one Modbus RTU response frame onto uart_byte_tx. Holds the payload in a local byte buffer and enforces the
//  T3.5 line-silence before the first byte. Sends the payload back-to-back, then appends CRC-16/Modbus, low byte first.

---
 rtl/modbus_pkg.sv | 40 ++++
 rtl/modbus_tx_frame_seq_if.sv | 12 +
 rtl/crc16_modbus.sv | 34 +++
 rtl/modbus_tx_frame_seq.sv | 148 ++++++++++++++
 tb/tb_modbus_tx_frame_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: line-silence timing helpers, CRC-16/Modbus constants
// and the one-hot frame sequencer state encoding.
package modbus_pkg;

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Above 19200 baud Modbus fixes T3.5 at 1.75 ms; below it is 3.5 chars of 11 bits.
  function automatic int t35_cycles(input longint clk_freq, input longint baud);
    longint c;
    if (baud > 64'sd19200) c = clk_freq * 1750 / 1000000;
    else c = clk_freq * 77 / (2 * baud);
    return int'(c);
  endfunction

  function automatic int t15_cycles(input longint clk_freq, input longint baud);
    longint c;
    if (baud > 64'sd19200) c = clk_freq * 750 / 1000000;
    else c = clk_freq * 33 / (2 * baud);
    return int'(c);
  endfunction

  typedef enum logic [7:0] {
    ST_IDLE      = 8'b0000_0001,
    ST_WAIT_T35  = 8'b0000_0010,
    ST_RD        = 8'b0000_0100,
    ST_SEND      = 8'b0000_1000,
    ST_WAIT_DONE = 8'b0001_0000,
    ST_CRC_LO    = 8'b0010_0000,
    ST_CRC_HI    = 8'b0100_0000,
    ST_DONE      = 8'b1000_0000
  } fsm_state_t;

  typedef enum logic [1:0] {
    PH_DATA   = 2'd0,
    PH_CRC_LO = 2'd1,
    PH_CRC_HI = 2'd2
  } tx_phase_t;

endpackage

// File: rtl/modbus_tx_frame_seq_if.sv
// Byte link between the frame sequencer (master) and uart_byte_tx (slave).
interface modbus_tx_frame_seq_if;
  // tx_start: one-cycle pulse, only while tx_state=0; tx_data is valid in that cycle.
  // tx_state stays high while the byte is on the wire; tx_done pulses once when it ends.
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       tx_state;

  modport master (output tx_data, output tx_start, input tx_done, input tx_state);
  modport slave  (input tx_data, input tx_start, output tx_done, output tx_state);
endinterface

// File: rtl/crc16_modbus.sv
// Bit-serial CRC-16/Modbus: loads one byte, then shifts it out over 8 cycles.
module crc16_modbus
  import modbus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        init,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out,
  output logic        crc_ready
);

  logic [15:0] crc_q;
  logic [3:0]  bits_left;

  // A byte offered while shifting is dropped; the sequencer never does that.
  always_ff @(posedge clk_in) begin
    if (rst_in || init) begin
      crc_q     <= CRC16_INIT;
      bits_left <= 4'd0;
    end else if (bits_left != 4'd0) begin
      crc_q     <= crc_q[0] ? ((crc_q >> 1) ^ CRC16_POLY) : (crc_q >> 1);
      bits_left <= bits_left - 4'd1;
    end else if (byte_valid) begin
      crc_q     <= crc_q ^ {8'h00, byte_in};
      bits_left <= 4'd8;
    end
  end

  assign crc_out   = crc_q;
  assign crc_ready = (bits_left == 4'd0);

endmodule

// File: rtl/modbus_tx_frame_seq.sv
// Sends one buffered Modbus RTU response frame plus CRC after T3.5 of line silence.
module modbus_tx_frame_seq
  import modbus_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int ADDR_W     = 8,
  parameter int T35_CYCLES = t35_cycles(longint'(CLK_FREQ), longint'(BAUD_RATE))
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  buf_we,
  input  logic [ADDR_W-1:0]     buf_waddr,
  input  logic [7:0]            buf_wdata,
  input  logic [ADDR_W-1:0]     frame_len,
  input  logic                  frame_start,
  modbus_tx_frame_seq_if.master tx,
  input  logic                  rx_state,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_len,
  output fsm_state_t            state_dbg
);

  localparam int BUF_DEPTH = 2 ** ADDR_W;
  localparam int CNT_W     = $clog2(T35_CYCLES + 1);
  localparam logic [CNT_W-1:0] T35_MAX = CNT_W'(T35_CYCLES);

  fsm_state_t        state, state_nxt;
  tx_phase_t         phase, phase_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt, len, len_nxt;
  logic [7:0]        tx_data_q, tx_byte, rd_data;
  logic [7:0]        mem [BUF_DEPTH];
  logic [CNT_W-1:0]  sil_cnt;
  logic              silent, tx_go, err_nxt, crc_init, crc_valid, crc_ready;
  logic [15:0]       crc;

  always_ff @(posedge clk_in) begin
    if (buf_we && !busy) mem[buf_waddr] <= buf_wdata;
    rd_data <= mem[idx];
  end

  // Any line or transmitter activity restarts the silence measurement.
  always_ff @(posedge clk_in) begin
    if (rst_in || rx_state || tx.tx_state || tx.tx_done) sil_cnt <= '0;
    else if (sil_cnt != T35_MAX) sil_cnt <= sil_cnt + CNT_W'(1);
  end
  assign silent = (sil_cnt == T35_MAX);

  crc16_modbus u_crc (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .init       (crc_init),
    .byte_valid (crc_valid),
    .byte_in    (rd_data),
    .crc_out    (crc),
    .crc_ready  (crc_ready)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      phase     <= PH_DATA;
      idx       <= '0;
      len       <= '0;
      tx_data_q <= 8'h00;
      err_len   <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      idx       <= idx_nxt;
      len       <= len_nxt;
      tx_data_q <= tx_byte;
      err_len   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    idx_nxt   = idx;
    len_nxt   = len;
    tx_byte   = tx_data_q;
    tx_go     = 1'b0;
    err_nxt   = 1'b0;
    crc_init  = 1'b0;
    crc_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          if (frame_len != '0) begin
            len_nxt   = frame_len;
            idx_nxt   = '0;
            phase_nxt = PH_DATA;
            crc_init  = 1'b1;
            state_nxt = ST_WAIT_T35;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_T35: if (silent && !tx.tx_state) state_nxt = ST_RD;
      ST_RD:       state_nxt = ST_SEND;
      ST_SEND: begin
        tx_go     = 1'b1;
        tx_byte   = rd_data;
        crc_valid = 1'b1;
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx.tx_done) begin
          case (phase)
            PH_DATA: begin
              idx_nxt   = idx + ADDR_W'(1);
              state_nxt = (idx < len - ADDR_W'(1)) ? ST_RD : ST_CRC_LO;
            end
            PH_CRC_LO: state_nxt = ST_CRC_HI;
            default:   state_nxt = ST_DONE;
          endcase
        end
      end
      // The CRC finishes 8 cycles after the last byte, long before its tx_done.
      ST_CRC_LO: begin
        if (crc_ready) begin
          tx_go     = 1'b1;
          tx_byte   = crc[7:0];
          phase_nxt = PH_CRC_LO;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_CRC_HI: begin
        tx_go     = 1'b1;
        tx_byte   = crc[15:8];
        phase_nxt = PH_CRC_HI;
        state_nxt = ST_WAIT_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tx.tx_start = tx_go;
  assign tx.tx_data  = tx_byte;
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign frame_done  = (state == ST_DONE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_modbus_tx_frame_seq.sv
// Bench for modbus_tx_frame_seq: UART byte-transmitter model, line monitor, CRC reference
// model and a byte scoreboard, driven by a directed sequence with randomized payloads.
module tb_modbus_tx_frame_seq;

  localparam int CLK_FREQ  = 100000;
  localparam int BAUD_RATE = 115200;
  localparam int ADDR_W    = 8;
  localparam int T35       = CLK_FREQ * 1750 / 1000000;  // 175 cycles: baud above 19200
  localparam int BUDGET    = 5000;

  logic              clk, rst_in, buf_we, frame_start, rx_state;
  logic [ADDR_W-1:0] buf_waddr, frame_len;
  logic [7:0]        buf_wdata, state_dbg;
  logic              busy, frame_done, err_len;

  modbus_tx_frame_seq_if tx_if ();

  modbus_tx_frame_seq #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .buf_we      (buf_we),
    .buf_waddr   (buf_waddr),
    .buf_wdata   (buf_wdata),
    .frame_len   (frame_len),
    .frame_start (frame_start),
    .tx          (tx_if),
    .rx_state    (rx_state),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_len     (err_len),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_cmp, n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         gap_q[$];
  int         start_count, done_count, fd_count, start_busy;
  int         last_start_cyc, last_done_cyc, last_act_cyc;

  // UART byte transmitter model: random character time per byte.
  initial begin : uart_model
    int chars;
    tx_if.tx_state = 1'b0;
    tx_if.tx_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_if.tx_start === 1'b1) begin
        chars = $urandom_range(12, 25);
        @(posedge clk);
        #1 tx_if.tx_state = 1'b1;
        repeat (chars) @(posedge clk);
        #1;
        tx_if.tx_state = 1'b0;
        tx_if.tx_done  = 1'b1;
        @(posedge clk);
        #1 tx_if.tx_done = 1'b0;
      end
    end
  end

  // Line monitor: captures sent bytes, start gaps and activity times.
  initial begin : monitor
    start_count = 0; done_count = 0; fd_count = 0; start_busy = 0;
    last_start_cyc = 0; last_done_cyc = 0; last_act_cyc = 0;
    forever begin
      @(negedge clk);
      if (tx_if.tx_start === 1'b1) begin
        start_count++;
        last_start_cyc = cyc;
        cap_q.push_back(tx_if.tx_data);
        gap_q.push_back(cyc - last_done_cyc);
        if (tx_if.tx_state === 1'b1) start_busy++;
      end
      if (tx_if.tx_done === 1'b1) begin
        done_count++;
        last_done_cyc = cyc;
      end
      if (tx_if.tx_done === 1'b1 || tx_if.tx_state === 1'b1) last_act_cyc = cyc;
      if (frame_done === 1'b1) fd_count++;
    end
  end

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int obs, input int lim);
    n_cmp++;
    assert (obs >= lim) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, lim);
    end
  endtask

  task automatic check_le(input string tag, input int obs, input int lim);
    n_cmp++;
    assert (obs <= lim) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected <= %0d", tag, obs, lim);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc_ref(input logic [7:0] p[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (p[i]) begin
      c = c ^ {8'h00, p[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic expect_frame(input logic [7:0] p[$]);
    logic [15:0] c;
    c = crc_ref(p);
    foreach (p[i]) exp_q.push_back(p[i]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic score(input string tag);
    logic [7:0] e, o;
    check({tag, "_nbytes"}, 32'(cap_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      o = cap_q.pop_front();
      check({tag, "_byte"}, 32'(o), 32'(e));
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_buf(input logic [7:0] p[$]);
    foreach (p[i]) begin
      buf_we    = 1'b1;
      buf_waddr = ADDR_W'(i);
      buf_wdata = p[i];
      tick();
    end
    buf_we = 1'b0;
  endtask

  task automatic start_frame(input int len);
    frame_len   = ADDR_W'(len);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic rand_payload(output logic [7:0] p[$]);
    int n;
    p.delete();
    n = $urandom_range(1, 24);
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_frame_done(input string tag);
    int base, n;
    base = fd_count;
    n = 0;
    while (fd_count == base && n < BUDGET) begin
      tick();
      n++;
    end
    check({tag, "_done_timeout"}, 32'(fd_count == base), 32'd0);
  endtask

  task automatic wait_first_start(input string tag, input int base);
    int n;
    n = 0;
    while (start_count == base && n < BUDGET) begin
      tick();
      n++;
    end
    check({tag, "_start_timeout"}, 32'(start_count == base), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [7:0] p1[$];
    logic [7:0] p[$];
    int base_fd, base_st, base_dn, rel, n, a_last_done, mx;

    n_cmp = 0; n_fail = 0;
    rst_in = 1'b1; buf_we = 1'b0; buf_waddr = '0; buf_wdata = 8'h00;
    frame_len = '0; frame_start = 1'b0; rx_state = 1'b0;
    p1 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};

    // reset values
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx_start", 32'(tx_if.tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_if.tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    tick();
    rst_in = 1'b0;

    // rx activity mid-silence, then the reference frame 01 03 00 00 00 01
    load_buf(p1);
    repeat (T35 / 2 - 6) tick();
    rx_state = 1'b1;
    repeat (100) tick();
    base_fd = fd_count;
    base_st = start_count;
    expect_frame(p1);
    rx_state = 1'b0;
    rel = cyc;
    start_frame(6);
    @(negedge clk);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_first_start("t2", base_st);
    check_ge("t2_t35_latency_min", last_start_cyc - rel, T35);
    check_le("t2_t35_latency_max", last_start_cyc - rel, T35 + 2);
    wait_frame_done("t1");
    repeat (T35 + 60) tick();
    score("t1");
    check("t1_frame_done_count", 32'(fd_count - base_fd), 32'd1);
    check("t1_start_count", 32'(start_count - base_st), 32'd8);
    check("t1_busy_after", 32'(busy), 32'd0);

    // zero-length request
    base_st = start_count;
    start_frame(0);
    @(negedge clk);
    check("t3_err_len_pulse", 32'(err_len), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    check("t3_err_len_cleared", 32'(err_len), 32'd0);
    repeat (T35 + 20) tick();
    check("t3_no_tx_start", 32'(start_count - base_st), 32'd0);
    check("t3_busy_after", 32'(busy), 32'd0);

    // writes and restarts while busy are ignored
    rand_payload(p);
    load_buf(p);
    base_fd = fd_count;
    expect_frame(p);
    start_frame(p.size());
    repeat (3) tick();
    buf_we = 1'b1; buf_waddr = '0; buf_wdata = 8'hFF;
    frame_start = 1'b1; frame_len = ADDR_W'(p.size());
    tick();
    buf_we = 1'b0; frame_start = 1'b0;
    wait_frame_done("t4a");
    repeat (T35 + 60) tick();
    score("t4a");
    check("t4_frame_done_count", 32'(fd_count - base_fd), 32'd1);
    expect_frame(p);
    start_frame(p.size());
    wait_frame_done("t4b");
    score("t4b_resend");

    // back-to-back frames: restart on the cycle after frame_done
    rand_payload(p);
    load_buf(p);
    repeat (T35 + 10) tick();
    gap_q.delete();
    expect_frame(p);
    expect_frame(p);
    start_frame(p.size());
    wait_frame_done("t6a");
    a_last_done = last_done_cyc;
    base_st = start_count;
    start_frame(p.size());
    wait_first_start("t6", base_st);
    check_ge("t6_interframe_gap", last_start_cyc - a_last_done, T35);
    wait_frame_done("t6b");
    score("t6");
    mx = 0;
    n = p.size() + 2;
    foreach (gap_q[i]) if (i != 0 && i != n && gap_q[i] > mx) mx = gap_q[i];
    check("t6_gap_count", 32'(gap_q.size()), 32'(2 * n));
    check_le("t6_intraframe_gap_max", mx, 3);

    // a few more random frames
    for (int k = 0; k < 3; k++) begin
      rand_payload(p);
      load_buf(p);
      expect_frame(p);
      start_frame(p.size());
      wait_frame_done("t7");
      score("t7_random");
    end

    // reset one cycle after the third tx_done of the reference frame
    load_buf(p1);
    base_dn = done_count;
    start_frame(6);
    n = 0;
    while (done_count < base_dn + 3 && n < BUDGET) begin
      tick();
      n++;
    end
    check("t5_third_done_timeout", 32'(done_count < base_dn + 3), 32'd0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    @(negedge clk);
    check("t5_rst_tx_start", 32'(tx_if.tx_start), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_frame_done", 32'(frame_done), 32'd0);
    check("t5_rst_err_len", 32'(err_len), 32'd0);
    check("t5_rst_tx_data", 32'(tx_if.tx_data), 32'h00);
    cap_q.delete();
    exp_q.delete();
    expect_frame(p1);
    base_st = start_count;
    tick();
    start_frame(6);
    wait_first_start("t5", base_st);
    check_ge("t5_silence_after_reset", last_start_cyc - last_act_cyc, T35);
    wait_frame_done("t5");
    score("t5");

    check("start_while_tx_busy", 32'(start_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
